// File: rtl/pipeline_2_pkg.sv
// Shared CPU constants for the ID/EX pipeline boundary: datapath, address and
// control-field widths plus the PC reset value.
package pipeline_2_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALUOP_W = 5;

  localparam int unsigned MEM_TO_REG_W = 2;
  localparam int unsigned ALU_SOURCE_W = 2;
  localparam int unsigned MEM_READ_W   = 3;
  localparam int unsigned MEM_WRITE_W  = 3;
  localparam int unsigned IMMI_SEL_W   = 3;

  // PC+4 resets to -4 so that the first fetched instruction lands at address 0.
  localparam logic [DATA_W-1:0] PC_RESET_VAL = 32'hFFFF_FFFC;

endpackage

// File: rtl/pipeline_2_if.sv
// Decode-to-execute bundle crossing the ID/EX register. The decode side is the
// master; the pipeline register is the slave.
interface pipeline_2_if;
  import pipeline_2_pkg::*;

  // decode-side fields
  logic                    BRANCH;
  logic                    REG_DEST;
  logic                    REG_WRITE;
  logic [MEM_TO_REG_W-1:0] MEM_TO_REG;
  logic [ALU_SOURCE_W-1:0] ALU_SOURCE;
  logic [MEM_READ_W-1:0]   MEM_READ;
  logic [MEM_WRITE_W-1:0]  MEM_WRITE;
  logic [IMMI_SEL_W-1:0]   IMMI_SEL;
  logic [ALUOP_W-1:0]      ALU_OP;
  logic [DATA_W-1:0]       OUT1;
  logic [DATA_W-1:0]       OUT2;
  logic [DATA_W-1:0]       PC_INCREMENT4;
  logic [DATA_W-1:0]       SIGN_EXTENDED;
  logic [REG_AW-1:0]       RD1;
  logic [REG_AW-1:0]       RD2;
  logic                    BUSY_WAIT;

  // execute-side registered copies
  logic                    BRANCH_OUT;
  logic                    REG_DEST_OUT;
  logic                    REG_WRITE_OUT;
  logic [MEM_TO_REG_W-1:0] MEM_TO_REG_OUT;
  logic [ALU_SOURCE_W-1:0] ALU_SOURCE_OUT;
  logic [MEM_READ_W-1:0]   MEM_READ_OUT;
  logic [MEM_WRITE_W-1:0]  MEM_WRITE_OUT;
  logic [IMMI_SEL_W-1:0]   IMMI_SEL_OUT;
  logic [ALUOP_W-1:0]      ALU_OP_OUT;
  logic [DATA_W-1:0]       OUT1_OUT;
  logic [DATA_W-1:0]       OUT2_OUT;
  logic [DATA_W-1:0]       PC_INCREMENT4_OUT;
  logic [DATA_W-1:0]       SIGN_EXTENDED_OUT;
  logic [REG_AW-1:0]       RD1_OUT;
  logic [REG_AW-1:0]       RD2_OUT;

  modport master (
    output BRANCH, REG_DEST, REG_WRITE, MEM_TO_REG, ALU_SOURCE, MEM_READ,
           MEM_WRITE, IMMI_SEL, ALU_OP, OUT1, OUT2, PC_INCREMENT4,
           SIGN_EXTENDED, RD1, RD2, BUSY_WAIT,
    input  BRANCH_OUT, REG_DEST_OUT, REG_WRITE_OUT, MEM_TO_REG_OUT,
           ALU_SOURCE_OUT, MEM_READ_OUT, MEM_WRITE_OUT, IMMI_SEL_OUT,
           ALU_OP_OUT, OUT1_OUT, OUT2_OUT, PC_INCREMENT4_OUT,
           SIGN_EXTENDED_OUT, RD1_OUT, RD2_OUT
  );

  modport slave (
    input  BRANCH, REG_DEST, REG_WRITE, MEM_TO_REG, ALU_SOURCE, MEM_READ,
           MEM_WRITE, IMMI_SEL, ALU_OP, OUT1, OUT2, PC_INCREMENT4,
           SIGN_EXTENDED, RD1, RD2, BUSY_WAIT,
    output BRANCH_OUT, REG_DEST_OUT, REG_WRITE_OUT, MEM_TO_REG_OUT,
           ALU_SOURCE_OUT, MEM_READ_OUT, MEM_WRITE_OUT, IMMI_SEL_OUT,
           ALU_OP_OUT, OUT1_OUT, OUT2_OUT, PC_INCREMENT4_OUT,
           SIGN_EXTENDED_OUT, RD1_OUT, RD2_OUT
  );

endinterface

// File: rtl/pipeline_2_pipe_field_reg.sv
// One pipeline-register field: width-parameterised flop with synchronous
// active-low reset to RST_VAL and a capture enable (low = hold).
module pipe_field_reg #(
  parameter int unsigned     W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] field_d;
  logic [W-1:0] field_q;

  always_comb begin
    field_d = field_q;
    if (en_i) field_d = d_i;
  end

  // NOTE: reset is tested inside the clocked block so it only acts on an edge
  // and wins over the hold; state is written with <= so every field samples
  // its input before any field updates on the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) field_q <= RST_VAL;
    else         field_q <= field_d;
  end

  assign q_o = field_q;

endmodule

// File: rtl/pipeline_2.sv
// ID/EX pipeline register: latches decode-stage results for the execute stage
// and holds them while the memory system reports BUSY_WAIT.
module pipeline_2
  import pipeline_2_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  pipeline_2_if.slave bus
);

  logic capture_en;
  assign capture_en = ~bus.BUSY_WAIT;

  pipe_field_reg #(.W(1)) u_branch (
    .clk_i(CLK), .rst_ni(RESET), .en_i(capture_en),
    .d_i(bus.BRANCH), .q_o(bus.BRANCH_OUT)
  );

  pipe_field_reg #(.W(1)) u_reg_dest (
    .clk_i(CLK), .rst_ni(RESET), .en_i(capture_en),
    .d_i(bus.REG_DEST), .q_o(bus.REG_DEST_OUT)
  );

  pipe_field_reg #(.W(1)) u_reg_write (
    .clk_i(CLK), .rst_ni(RESET), .en_i(capture_en),
    .d_i(bus.REG_WRITE), .q_o(bus.REG_WRITE_OUT)
  );

  pipe_field_reg #(.W(MEM_TO_REG_W)) u_mem_to_reg (
    .clk_i(CLK), .rst_ni(RESET), .en_i(capture_en),
    .d_i(bus.MEM_TO_REG), .q_o(bus.MEM_TO_REG_OUT)
  );

  pipe_field_reg #(.W(ALU_SOURCE_W)) u_alu_source (
    .clk_i(CLK), .rst_ni(RESET), .en_i(capture_en),
    .d_i(bus.ALU_SOURCE), .q_o(bus.ALU_SOURCE_OUT)
  );

  pipe_field_reg #(.W(MEM_READ_W)) u_mem_read (
    .clk_i(CLK), .rst_ni(RESET), .en_i(capture_en),
    .d_i(bus.MEM_READ), .q_o(bus.MEM_READ_OUT)
  );

  pipe_field_reg #(.W(MEM_WRITE_W)) u_mem_write (
    .clk_i(CLK), .rst_ni(RESET), .en_i(capture_en),
    .d_i(bus.MEM_WRITE), .q_o(bus.MEM_WRITE_OUT)
  );

  pipe_field_reg #(.W(IMMI_SEL_W)) u_immi_sel (
    .clk_i(CLK), .rst_ni(RESET), .en_i(capture_en),
    .d_i(bus.IMMI_SEL), .q_o(bus.IMMI_SEL_OUT)
  );

  pipe_field_reg #(.W(ALUOP_W)) u_alu_op (
    .clk_i(CLK), .rst_ni(RESET), .en_i(capture_en),
    .d_i(bus.ALU_OP), .q_o(bus.ALU_OP_OUT)
  );

  pipe_field_reg #(.W(DATA_W)) u_out1 (
    .clk_i(CLK), .rst_ni(RESET), .en_i(capture_en),
    .d_i(bus.OUT1), .q_o(bus.OUT1_OUT)
  );

  pipe_field_reg #(.W(DATA_W)) u_out2 (
    .clk_i(CLK), .rst_ni(RESET), .en_i(capture_en),
    .d_i(bus.OUT2), .q_o(bus.OUT2_OUT)
  );

  // The only field with a nonzero reset value.
  pipe_field_reg #(.W(DATA_W), .RST_VAL(PC_RESET_VAL)) u_pc_increment4 (
    .clk_i(CLK), .rst_ni(RESET), .en_i(capture_en),
    .d_i(bus.PC_INCREMENT4), .q_o(bus.PC_INCREMENT4_OUT)
  );

  pipe_field_reg #(.W(DATA_W)) u_sign_extended (
    .clk_i(CLK), .rst_ni(RESET), .en_i(capture_en),
    .d_i(bus.SIGN_EXTENDED), .q_o(bus.SIGN_EXTENDED_OUT)
  );

  pipe_field_reg #(.W(REG_AW)) u_rd1 (
    .clk_i(CLK), .rst_ni(RESET), .en_i(capture_en),
    .d_i(bus.RD1), .q_o(bus.RD1_OUT)
  );

  pipe_field_reg #(.W(REG_AW)) u_rd2 (
    .clk_i(CLK), .rst_ni(RESET), .en_i(capture_en),
    .d_i(bus.RD2), .q_o(bus.RD2_OUT)
  );

endmodule

// File: tb/tb_pipeline_2.sv
// Self-checking bench for the ID/EX register: directed scenarios then random
// reset/stall/capture traffic against a field-record reference model.
module tb_pipeline_2;
  import pipeline_2_pkg::*;

  typedef struct packed {
    logic        branch;
    logic        reg_dest;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic [1:0]  alu_source;
    logic [2:0]  mem_read;
    logic [2:0]  mem_write;
    logic [2:0]  immi_sel;
    logic [4:0]  alu_op;
    logic [31:0] out1;
    logic [31:0] out2;
    logic [31:0] pc4;
    logic [31:0] sext;
    logic [4:0]  rd1;
    logic [4:0]  rd2;
  } fields_t;

  logic CLK;
  logic RESET;
  int   n_checks;
  int   n_fail;
  fields_t exp_q;

  pipeline_2_if bus ();

  pipeline_2 dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic fields_t reset_fields();
    fields_t f = '0;
    f.pc4 = 32'hFFFF_FFFC;
    return f;
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    f.branch     = 1'($urandom);
    f.reg_dest   = 1'($urandom);
    f.reg_write  = 1'($urandom);
    f.mem_to_reg = 2'($urandom);
    f.alu_source = 2'($urandom);
    f.mem_read   = 3'($urandom);
    f.mem_write  = 3'($urandom);
    f.immi_sel   = 3'($urandom);
    f.alu_op     = 5'($urandom);
    f.out1       = $urandom;
    f.out2       = $urandom;
    f.pc4        = $urandom;
    f.sext       = $urandom;
    f.rd1        = 5'($urandom);
    f.rd2        = 5'($urandom);
    return f;
  endfunction

  task automatic drive(input fields_t f, input logic rst_n, input logic busy);
    bus.BRANCH        = f.branch;
    bus.REG_DEST      = f.reg_dest;
    bus.REG_WRITE     = f.reg_write;
    bus.MEM_TO_REG    = f.mem_to_reg;
    bus.ALU_SOURCE    = f.alu_source;
    bus.MEM_READ      = f.mem_read;
    bus.MEM_WRITE     = f.mem_write;
    bus.IMMI_SEL      = f.immi_sel;
    bus.ALU_OP        = f.alu_op;
    bus.OUT1          = f.out1;
    bus.OUT2          = f.out2;
    bus.PC_INCREMENT4 = f.pc4;
    bus.SIGN_EXTENDED = f.sext;
    bus.RD1           = f.rd1;
    bus.RD2           = f.rd2;
    bus.BUSY_WAIT     = busy;
    RESET             = rst_n;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".BRANCH"},     32'(bus.BRANCH_OUT),        32'(exp_q.branch));
    check({tag, ".REG_DEST"},   32'(bus.REG_DEST_OUT),      32'(exp_q.reg_dest));
    check({tag, ".REG_WRITE"},  32'(bus.REG_WRITE_OUT),     32'(exp_q.reg_write));
    check({tag, ".MEM_TO_REG"}, 32'(bus.MEM_TO_REG_OUT),    32'(exp_q.mem_to_reg));
    check({tag, ".ALU_SOURCE"}, 32'(bus.ALU_SOURCE_OUT),    32'(exp_q.alu_source));
    check({tag, ".MEM_READ"},   32'(bus.MEM_READ_OUT),      32'(exp_q.mem_read));
    check({tag, ".MEM_WRITE"},  32'(bus.MEM_WRITE_OUT),     32'(exp_q.mem_write));
    check({tag, ".IMMI_SEL"},   32'(bus.IMMI_SEL_OUT),      32'(exp_q.immi_sel));
    check({tag, ".ALU_OP"},     32'(bus.ALU_OP_OUT),        32'(exp_q.alu_op));
    check({tag, ".OUT1"},       bus.OUT1_OUT,               exp_q.out1);
    check({tag, ".OUT2"},       bus.OUT2_OUT,               exp_q.out2);
    check({tag, ".PC4"},        bus.PC_INCREMENT4_OUT,      exp_q.pc4);
    check({tag, ".SEXT"},       bus.SIGN_EXTENDED_OUT,      exp_q.sext);
    check({tag, ".RD1"},        32'(bus.RD1_OUT),           32'(exp_q.rd1));
    check({tag, ".RD2"},        32'(bus.RD2_OUT),           32'(exp_q.rd2));
  endtask

  // One clock: apply inputs at the falling edge, update the model at the
  // rising edge (reset first, then stall, else capture), check 2 ns later,
  // then optionally scramble the inputs and confirm the outputs stay put.
  task automatic step(input string tag, input fields_t f, input logic rst_n,
                      input logic busy, input bit glitch);
    @(negedge CLK);
    drive(f, rst_n, busy);
    @(posedge CLK);
    if (!rst_n)     exp_q = reset_fields();
    else if (!busy) exp_q = f;
    #2;
    check_all(tag);
    if (glitch) begin
      for (int g = 0; g < 2; g++) begin
        #1;
        drive(rand_fields(), 1'($urandom), 1'($urandom));
        check_all({tag, ".glitch"});
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    fields_t cap;
    fields_t stl;
    n_checks = 0;
    n_fail   = 0;
    exp_q    = reset_fields();

    // Reset with nonzero inputs present.
    cap = '0;
    cap.branch = 1'b1; cap.alu_source = 2'd2; cap.out1 = 32'd10; cap.pc4 = 32'd10;
    drive(cap, 1'b0, 1'b0);
    step("reset", cap, 1'b0, 1'b0, 1'b0);

    // Directed capture.
    cap = '{branch: 1'b1, reg_dest: 1'b0, reg_write: 1'b1, mem_to_reg: 2'd1,
            alu_source: 2'd2, mem_read: 3'd3, mem_write: 3'd4, immi_sel: 3'd2,
            alu_op: 5'd4, out1: 32'd10, out2: 32'd12, pc4: 32'd10,
            sext: 32'd15, rd1: 5'd5, rd2: 5'd8};
    step("capture", cap, 1'b1, 1'b0, 1'b0);

    // Stall: new inputs ignored, then released and captured.
    stl = cap;
    stl.alu_source = 2'd3; stl.out1 = 32'd14; stl.out2 = 32'd17;
    step("stall", stl, 1'b1, 1'b1, 1'b0);
    step("stall2", stl, 1'b1, 1'b1, 1'b0);
    step("release", stl, 1'b1, 1'b0, 1'b0);

    // Reset asserted mid-stall.
    step("stall_pre_rst", rand_fields(), 1'b1, 1'b1, 1'b0);
    step("rst_in_stall", rand_fields(), 1'b0, 1'b1, 1'b0);

    // Glitch immunity after a capture and after a stall.
    step("glitch_cap", rand_fields(), 1'b1, 1'b0, 1'b1);
    step("glitch_stall", rand_fields(), 1'b1, 1'b1, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand", rand_fields(), ($urandom_range(15) != 0),
           ($urandom_range(2) == 0), ($urandom_range(3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
